// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with the EX-stage operand network.
// Holds the decoded instruction for EX, forwards EX/MEM and MEM/WB results to
// resolve RAW hazards, selects ALU operands, and requests a stall on load-use.
module ex_operand_stage #(
   parameter int DATAW  = 32,
   parameter int ALUOPW = 8,
   parameter int REGW   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATAW-1:0]  id_pc,
   input  logic [DATAW-1:0]  id_rs1_data,
   input  logic [DATAW-1:0]  id_rs2_data,
   input  logic [DATAW-1:0]  id_imm,
   input  logic [REGW-1:0]   id_rs1,
   input  logic [REGW-1:0]   id_rs2,
   input  logic [REGW-1:0]   id_rd,
   input  logic [ALUOPW-1:0] id_aluop,
   input  logic              id_asel_pc,
   input  logic              id_bsel_imm,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              exmem_reg_write,
   input  logic [REGW-1:0]   exmem_rd,
   input  logic [DATAW-1:0]  exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REGW-1:0]   memwb_rd,
   input  logic [DATAW-1:0]  memwb_result,
   output logic              ex_valid,
   output logic [DATAW-1:0]  alu_da,
   output logic [DATAW-1:0]  alu_db,
   output logic [ALUOPW-1:0] ex_aluop,
   output logic [DATAW-1:0]  ex_store_data,
   output logic [DATAW-1:0]  ex_pc,
   output logic [REGW-1:0]   ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              load_use_hazard
);

   // EX-stage copies of the decoded instruction
   logic              vld_p1;
   logic [DATAW-1:0]  pc_p1;
   logic [DATAW-1:0]  rs1_data_p1;
   logic [DATAW-1:0]  rs2_data_p1;
   logic [DATAW-1:0]  imm_p1;
   logic [REGW-1:0]   rs1_p1;
   logic [REGW-1:0]   rs2_p1;
   logic [REGW-1:0]   rd_p1;
   logic [ALUOPW-1:0] aluop_p1;
   logic              asel_pc_p1;
   logic              bsel_imm_p1;
   logic              reg_write_p1;
   logic              mem_read_p1;
   logic              mem_write_p1;

   logic [DATAW-1:0]  fwd_rs1;
   logic [DATAW-1:0]  fwd_rs2;

   // Youngest matching producer wins; x0 is hard-wired zero and never forwarded.
   function automatic logic [DATAW-1:0] fwd_sel(
      input logic [REGW-1:0]  rs,
      input logic [DATAW-1:0] reg_data,
      input logic             em_we,
      input logic [REGW-1:0]  em_rd,
      input logic [DATAW-1:0] em_res,
      input logic             wb_we,
      input logic [REGW-1:0]  wb_rd,
      input logic [DATAW-1:0] wb_res
   );
      logic [DATAW-1:0] sel;
      sel = reg_data;
      if (em_we && (em_rd != '0) && (em_rd == rs)) begin
         sel = em_res;
      end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
         sel = wb_res;
      end
      return sel;
   endfunction

   // A load in EX whose destination is read by the instruction in ID cannot be
   // forwarded in time: hold ID upstream and let a bubble into EX instead.
   assign load_use_hazard = vld_p1 & mem_read_p1 & id_valid & (rd_p1 != '0) &
                            ((rd_p1 == id_rs1) | (rd_p1 == id_rs2));

   // ---- ID -> EX boundary: rst > flush > stall > load-use bubble > capture
   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && load_use_hazard)) begin
         vld_p1       <= 1'b0;
         pc_p1        <= '0;
         rs1_data_p1  <= '0;
         rs2_data_p1  <= '0;
         imm_p1       <= '0;
         rs1_p1       <= '0;
         rs2_p1       <= '0;
         rd_p1        <= '0;
         aluop_p1     <= '0;
         asel_pc_p1   <= 1'b0;
         bsel_imm_p1  <= 1'b0;
         reg_write_p1 <= 1'b0;
         mem_read_p1  <= 1'b0;
         mem_write_p1 <= 1'b0;
      end else if (!stall) begin
         vld_p1       <= id_valid;
         pc_p1        <= id_pc;
         rs1_data_p1  <= id_rs1_data;
         rs2_data_p1  <= id_rs2_data;
         imm_p1       <= id_imm;
         rs1_p1       <= id_rs1;
         rs2_p1       <= id_rs2;
         rd_p1        <= id_rd;
         aluop_p1     <= id_aluop;
         asel_pc_p1   <= id_asel_pc;
         bsel_imm_p1  <= id_bsel_imm;
         reg_write_p1 <= id_reg_write;
         mem_read_p1  <= id_mem_read;
         mem_write_p1 <= id_mem_write;
      end
   end

   // Forwarding network, resolved independently for each source register
   always_comb begin
      fwd_rs1 = fwd_sel(rs1_p1, rs1_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result);
      fwd_rs2 = fwd_sel(rs2_p1, rs2_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result);
   end

   assign alu_da        = asel_pc_p1  ? pc_p1  : fwd_rs1;
   assign alu_db        = bsel_imm_p1 ? imm_p1 : fwd_rs2;
   // Stores always need the rs2 value even when operand B carries the offset.
   assign ex_store_data = fwd_rs2;
   assign ex_valid      = vld_p1;
   assign ex_aluop      = aluop_p1;
   assign ex_pc         = pc_p1;
   assign ex_rd         = rd_p1;
   assign ex_reg_write  = reg_write_p1;
   assign ex_mem_read   = mem_read_p1;
   assign ex_mem_write  = mem_write_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed scenarios plus a randomized run
// checked against a field-level reference model of the EX slot.
module tb_ex_operand_stage;
   localparam int DATAW  = 32;
   localparam int ALUOPW = 8;
   localparam int REGW   = 5;

   logic              clk = 1'b0;
   logic              rst, stall, flush;
   logic              id_valid;
   logic [DATAW-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [REGW-1:0]   id_rs1, id_rs2, id_rd;
   logic [ALUOPW-1:0] id_aluop;
   logic              id_asel_pc, id_bsel_imm, id_reg_write, id_mem_read, id_mem_write;
   logic              exmem_reg_write, memwb_reg_write;
   logic [REGW-1:0]   exmem_rd, memwb_rd;
   logic [DATAW-1:0]  exmem_result, memwb_result;
   logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
   logic [DATAW-1:0]  alu_da, alu_db, ex_store_data, ex_pc;
   logic [ALUOPW-1:0] ex_aluop;
   logic [REGW-1:0]   ex_rd;

   int errors = 0;
   int checks = 0;

   ex_operand_stage #(.DATAW(DATAW), .ALUOPW(ALUOPW), .REGW(REGW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_aluop(id_aluop), .id_asel_pc(id_asel_pc),
      .id_bsel_imm(id_bsel_imm), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .alu_da(alu_da), .alu_db(alu_db), .ex_aluop(ex_aluop),
      .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .load_use_hazard(load_use_hazard)
   );

   always #5 clk = ~clk;

   // Contents of the EX slot as the architecture sees it
   typedef struct packed {
      logic              valid;
      logic [DATAW-1:0]  pc, rs1d, rs2d, imm;
      logic [REGW-1:0]   rs1, rs2, rd;
      logic [ALUOPW-1:0] aluop;
      logic              asel, bsel, rw, mr, mw;
   } ex_slot_t;

   ex_slot_t m;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rst = 0; stall = 0; flush = 0;
      id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_aluop = '0;
      id_asel_pc = 0; id_bsel_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
      memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
   endtask

   task automatic drive_random_id();
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = REGW'($urandom_range(0, 7)); id_rs2 = REGW'($urandom_range(0, 7));
      id_rd = REGW'($urandom_range(0, 7)); id_aluop = ALUOPW'($urandom);
      id_asel_pc = 1'($urandom); id_bsel_imm = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom);
   endtask

   // Register value seen by EX: newest in-flight writer of a nonzero register wins
   function automatic logic [DATAW-1:0] ref_fwd(input logic [REGW-1:0] idx,
                                                 input logic [DATAW-1:0] file_val);
      if (idx == 0) return file_val;
      if (exmem_reg_write && exmem_rd == idx) return exmem_result;
      if (memwb_reg_write && memwb_rd == idx) return memwb_result;
      return file_val;
   endfunction

   task automatic test_reset();
      drive_idle();
      rst = 1;
      drive_random_id();
      id_valid = 1;
      exmem_reg_write = 1; exmem_rd = REGW'($urandom_range(1, 31)); exmem_result = $urandom;
      memwb_reg_write = 1; memwb_rd = REGW'($urandom_range(1, 31)); memwb_result = $urandom;
      tick();
      tick();
      checks++;
      if ({ex_valid, alu_da, alu_db, ex_aluop, ex_store_data, ex_pc, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b da=%h db=%h op=%h st=%h pc=%h rd=%0d, required all 0",
                  ex_valid, alu_da, alu_db, ex_aluop, ex_store_data, ex_pc, ex_rd);
      end
      checks++;
      if (load_use_hazard !== 1'b0) begin
         errors++;
         $display("FAIL reset_hazard: got %b, required 0", load_use_hazard);
      end
      drive_idle();
   endtask

   task automatic test_pass_through();
      drive_idle();
      id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 4; id_rs1_data = 32'h10;
      id_rs2_data = 32'h77; id_imm = 32'hFFFF_FFFC; id_bsel_imm = 1; id_aluop = 8'h5A;
      tick();
      checks++;
      if (alu_da !== 32'h10) begin
         errors++; $display("FAIL pass_da: got %h, required 00000010", alu_da);
      end
      checks++;
      if (alu_db !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL pass_db: got %h, required fffffffc", alu_db);
      end
      checks++;
      if (ex_aluop !== 8'h5A || ex_valid !== 1'b1 || ex_store_data !== 32'h77) begin
         errors++;
         $display("FAIL pass_ctrl: op=%h valid=%b st=%h, required op=5a valid=1 st=00000077",
                  ex_aluop, ex_valid, ex_store_data);
      end
   endtask

   task automatic test_forward_priority();
      drive_idle();
      id_valid = 1; id_rs1 = 5; id_rs2 = 6; id_rs1_data = 32'h1111; id_rs2_data = 32'h2222;
      tick();
      drive_idle();
      exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAAAA_0000;
      memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h5555;
      #1;
      checks++;
      if (alu_da !== 32'hAAAA_0000) begin
         errors++; $display("FAIL fwd_exmem_prio: got %h, required aaaa0000", alu_da);
      end
      exmem_reg_write = 0;
      #1;
      checks++;
      if (alu_da !== 32'h5555) begin
         errors++; $display("FAIL fwd_memwb: got %h, required 00005555", alu_da);
      end
      memwb_rd = 6; memwb_result = 32'h6666;
      #1;
      checks++;
      if (alu_db !== 32'h6666 || ex_store_data !== 32'h6666 || alu_da !== 32'h1111) begin
         errors++;
         $display("FAIL fwd_rs2: db=%h st=%h da=%h, required db=00006666 st=00006666 da=00001111",
                  alu_db, ex_store_data, alu_da);
      end
   endtask

   task automatic test_x0_guard();
      drive_idle();
      id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rs2_data = '0;
      tick();
      drive_idle();
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h1234;
      memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'h5678;
      #1;
      checks++;
      if (alu_db !== 32'h0 || ex_store_data !== 32'h0 || alu_da !== 32'h0) begin
         errors++;
         $display("FAIL x0_guard: db=%h st=%h da=%h, required 0", alu_db, ex_store_data, alu_da);
      end
   endtask

   task automatic test_load_use();
      drive_idle();
      id_valid = 1; id_rd = 3; id_rs1 = 1; id_mem_read = 1; id_reg_write = 1;
      tick();
      drive_idle();
      id_valid = 1; id_rs1 = 4; id_rs2 = 3; id_rd = 7; id_reg_write = 1;
      id_rs1_data = 32'h44; id_rs2_data = 32'hDEAD;
      #1;
      checks++;
      if (load_use_hazard !== 1'b1) begin
         errors++; $display("FAIL lu_detect: got %b, required 1", load_use_hazard);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
          ex_mem_write !== 1'b0 || load_use_hazard !== 1'b0) begin
         errors++;
         $display("FAIL lu_bubble: valid=%b rw=%b mr=%b mw=%b hz=%b, required all 0",
                  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard);
      end
      tick();
      memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hCAFE_F00D;
      #1;
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || alu_db !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL lu_dependent: valid=%b rd=%0d db=%h, required valid=1 rd=7 db=cafef00d",
                  ex_valid, ex_rd, alu_db);
      end
   endtask

   task automatic test_flush_stall();
      drive_idle();
      id_valid = 1; id_rd = 8; id_reg_write = 1; id_mem_write = 1; id_mem_read = 1;
      stall = 1; flush = 1;
      tick();
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
          ex_mem_write !== 1'b0 || ex_rd !== '0) begin
         errors++;
         $display("FAIL flush_stall: valid=%b rw=%b mr=%b mw=%b rd=%0d, required all 0",
                  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd);
      end
   endtask

   task automatic test_stall_hold();
      drive_idle();
      id_valid = 1; id_pc = 32'h100; id_rs1 = 1; id_rs2 = 2; id_rd = 9;
      id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_imm = 32'h33;
      id_bsel_imm = 1; id_aluop = 8'h3C; id_reg_write = 1;
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         drive_random_id();
         tick();
         checks++;
         if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || alu_da !== 32'h11 ||
             alu_db !== 32'h33 || ex_store_data !== 32'h22 || ex_aluop !== 8'h3C ||
             ex_rd !== 5'd9 || ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0 ||
             ex_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: valid=%b pc=%h da=%h db=%h st=%h op=%h rd=%0d, required 1 00000100 00000011 00000033 00000022 3c 9",
                     i, ex_valid, ex_pc, alu_da, alu_db, ex_store_data, ex_aluop, ex_rd);
         end
      end
      drive_idle();
   endtask

   task automatic test_reset_mid_hazard();
      drive_idle();
      id_valid = 1; id_rd = 2; id_mem_read = 1; id_reg_write = 1;
      tick();
      id_valid = 1; id_rs1 = 2; id_rd = 5; id_mem_read = 0;
      stall = 1;
      rst = 1;
      tick();
      checks++;
      if (ex_valid !== 1'b0 || load_use_hazard !== 1'b0 || ex_mem_read !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_hazard: valid=%b hz=%b mr=%b, required 0 0 0",
                  ex_valid, load_use_hazard, ex_mem_read);
      end
      drive_idle();
   endtask

   task automatic test_random();
      logic              hz;
      logic [DATAW-1:0]  e_da, e_db, e_st;
      drive_idle();
      rst = 1;
      tick();
      m = '0;
      for (int c = 0; c < 400; c++) begin
         rst   = ($urandom_range(0, 49) == 0);
         stall = ($urandom_range(0, 6) == 0);
         flush = ($urandom_range(0, 9) == 0);
         drive_random_id();
         exmem_reg_write = 1'($urandom); exmem_rd = REGW'($urandom_range(0, 7));
         exmem_result = $urandom;
         memwb_reg_write = 1'($urandom); memwb_rd = REGW'($urandom_range(0, 7));
         memwb_result = $urandom;
         #1;
         hz   = m.valid && m.mr && id_valid && (m.rd != 0) &&
                ((m.rd == id_rs1) || (m.rd == id_rs2));
         e_st = ref_fwd(m.rs2, m.rs2d);
         e_da = m.asel ? m.pc : ref_fwd(m.rs1, m.rs1d);
         e_db = m.bsel ? m.imm : e_st;
         checks++;
         if (load_use_hazard !== hz) begin
            errors++;
            $display("FAIL rand_hazard[%0d]: got %b, required %b", c, load_use_hazard, hz);
         end
         checks++;
         if (alu_da !== e_da || alu_db !== e_db || ex_store_data !== e_st) begin
            errors++;
            $display("FAIL rand_operands[%0d]: da=%h db=%h st=%h, required %h %h %h",
                     c, alu_da, alu_db, ex_store_data, e_da, e_db, e_st);
         end
         checks++;
         if ({ex_valid, ex_pc, ex_aluop, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write} !==
             {m.valid, m.pc, m.aluop, m.rd, m.rw, m.mr, m.mw}) begin
            errors++;
            $display("FAIL rand_ctrl[%0d]: v=%b pc=%h op=%h rd=%0d rw/mr/mw=%b%b%b, required %b %h %h %0d %b%b%b",
                     c, ex_valid, ex_pc, ex_aluop, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
                     m.valid, m.pc, m.aluop, m.rd, m.rw, m.mr, m.mw);
         end
         if (rst || flush) m = '0;
         else if (stall) m = m;
         else if (hz) m = '0;
         else m = '{valid: id_valid, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data,
                    imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, aluop: id_aluop,
                    asel: id_asel_pc, bsel: id_bsel_imm, rw: id_reg_write,
                    mr: id_mem_read, mw: id_mem_write};
         tick();
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      rst = 1;
      #2;
      test_reset();
      test_pass_through();
      test_forward_priority();
      test_x0_guard();
      test_load_use();
      test_flush_stall();
      test_stall_hold();
      test_reset_mid_hazard();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand network; sits directly upstream of the ALU.
- Captures decoded instruction fields, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU operand and control inputs (alu_da, alu_db, ex_aluop).
- Detects load-use hazards and requests an upstream stall while inserting a bubble into EX.

Parameters:
- DATAW, 32, datapath width; matches `datawidth.
- ALUOPW, 8, ALU control width; matches `ALU_CLT, carries {funct7 bit, funct3, class bits} unchanged.
- REGW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  replace stage contents with a bubble (branch/jump redirect).
- id_valid  in  1  ID slot holds a real instruction.
- id_pc  in  DATAW  instruction PC.
- id_rs1_data, id_rs2_data  in  DATAW each  register-file read data.
- id_imm  in  DATAW  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REGW each  register indices.
- id_aluop  in  ALUOPW  ALU control.
- id_asel_pc  in  1  operand A = PC instead of rs1.
- id_bsel_imm  in  1  operand B = immediate instead of rs2.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits.
- exmem_reg_write  in  1, exmem_rd  in  REGW, exmem_result  in  DATAW  EX/MEM forwarding source.
- memwb_reg_write  in  1, memwb_rd  in  REGW, memwb_result  in  DATAW  MEM/WB forwarding source.
- ex_valid  out  1  EX slot holds a real instruction.
- alu_da, alu_db  out  DATAW each  ALU operands.
- ex_aluop  out  ALUOPW  registered ALU control.
- ex_store_data  out  DATAW  forwarded rs2 value for stores.
- ex_pc  out  DATAW; ex_rd  out  REGW; ex_reg_write, ex_mem_read, ex_mem_write  out  1 each.
- load_use_hazard  out  1  combinational stall request to PC/IF/ID.

Behaviour:
- Registered state: valid, pc, rs1/rs2 data, imm, rs1/rs2/rd indices, aluop, asel/bsel, reg_write/mem_read/mem_write.
- Update priority each edge: rst > flush > stall > load_use_hazard > normal load.
  - rst: every register is 0, so every output reads 0 after reset (operands 0 because x0 is never forwarded).
  - flush: bubble. valid, reg_write, mem_read, mem_write = 0; rd = 0; other fields don't-care but cleared to 0.
  - stall: all registers hold.
  - load_use_hazard: bubble as for flush; upstream holds ID via this signal.
  - normal: capture id_* fields. Latency 1 cycle, ID to EX.
- Flush and stall together: flush wins and a bubble is written.
- load_use_hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - Purely combinational from the stage registers and id_* inputs; asserted regardless of stall/flush.
- Forwarding is combinational, computed separately for rs1 and rs2 from the registered indices:
  - If exmem_reg_write & exmem_rd != 0 & exmem_rd == rsN, use exmem_result.
  - Else if memwb_reg_write & memwb_rd != 0 & memwb_rd == rsN, use memwb_result.
  - Else use the registered rsN data.
  - EX/MEM has priority over MEM/WB. Index 0 is never forwarded.
- Operand selection:
  - alu_da = asel_pc ? ex_pc : fwd_rs1.
  - alu_db = bsel_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always, independent of bsel_imm.
- Bubbles: forwarding and operand outputs may toggle, but ex_valid = 0 and all write/memory enables = 0, so the bubble has no architectural effect.
- Load followed by a dependent instruction:
  - Edge after the hazard: bubble in EX.
  - Following cycle: the load is in MEM/WB and the dependent instruction reaches EX, taking the MEM/WB value.
- Reset asserted mid-stall or mid-hazard: the stage clears on the next edge; load_use_hazard drops because ex_valid = 0.

Test Plan:
- Reset: hold rst 2 cycles with random id_* inputs -> all outputs 0, load_use_hazard = 0.
- Pass-through: id_rs1_data = 0x10, id_imm = 0xFFFFFFFC, id_bsel_imm = 1, no forwarding matches -> next cycle alu_da = 0x10, alu_db = 0xFFFFFFFC, ex_aluop = id_aluop.
- Forward priority: EX rs1 = 5; exmem_rd = 5 with 0xAAAA0000 and memwb_rd = 5 with 0x5555 -> alu_da = 0xAAAA0000. Deassert exmem_reg_write -> alu_da = 0x5555.
- x0 guard: rs2 = 0, exmem_rd = 0, exmem_reg_write = 1, result 0x1234 -> alu_db = registered rs2 data (0).
- Load-use: lw x3 in EX (ex_mem_read = 1), id_rs2 = 3 -> load_use_hazard = 1; next edge ex_valid = 0, ex_reg_write = 0; dependent then enters EX and takes memwb_result on rs2.
- Flush + stall together with a valid ID instruction -> next cycle ex_valid = 0 and all enables 0. Stall alone for 3 cycles -> outputs hold their values unchanged.
